// File: rtl/dec139_scan_pkg.sv
// Shared types and constants for the dual 2-to-4 demux scan driver.
package dec139_scan_pkg;

  localparam int unsigned NUM_CH   = 8;
  localparam int unsigned CH_W     = 3;
  localparam int unsigned HALF_BIT = 2;
  localparam int unsigned BLANK_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Channels 4-7 live on half B of the demux.
  function automatic logic is_half_b(input logic [CH_W-1:0] ch);
    return ch[HALF_BIT];
  endfunction

endpackage

// File: rtl/dec139_next_ch.sv
// Combinational channel finder: next-higher set mask bit above cur, and lowest set bit.
module dec139_next_ch
  import dec139_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   next,
  output logic              found,
  output logic [CH_W-1:0]   first
);

  // Scan high to low so the last hit is the lowest qualifying bit.
  always_comb begin
    next  = '0;
    found = 1'b0;
    first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first = CH_W'(i);
        if (CH_W'(i) > cur) begin
          next  = CH_W'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dec139_scan_driver.sv
// Scan driver for a dual 2-to-4 demux: blanked, dwell-timed strobing of 8 channels.
// Optional DEC139_SCAN_HOLD_EN adds a hold input that freezes an in-progress scan.
module dec139_scan_driver
  import dec139_scan_pkg::*;
#(
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NUM_CH-1:0]  ch_mask,
`ifdef DEC139_SCAN_HOLD_EN
  input  logic               hold,
`endif
  output logic [1:0]         sel_a,
  output logic               en_a_n,
  output logic [1:0]         sel_b,
  output logic               en_b_n,
  output logic [CH_W-1:0]    chan,
  output logic               busy,
  output logic               frame_done
);

  state_t               state;
  logic [DWELL_W-1:0]   dwell_q;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [BLANK_W-1:0]   blank_cnt;
  logic [NUM_CH-1:0]    mask_q;
  logic                 cont_q;
  logic                 hold_act;

  logic [NUM_CH-1:0]    mask_sel;
  logic [CH_W-1:0]      ch_next;
  logic                 ch_found;
  logic [CH_W-1:0]      ch_first;

`ifdef DEC139_SCAN_HOLD_EN
  assign hold_act = hold;
`else
  assign hold_act = 1'b0;
`endif

  // In IDLE the finder looks at the incoming mask so the first channel is ready at start.
  assign mask_sel = (state == IDLE) ? ch_mask : mask_q;

  dec139_next_ch u_next_ch (
    .mask  (mask_sel),
    .cur   (chan),
    .next  (ch_next),
    .found (ch_found),
    .first (ch_first)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      en_a_n     <= 1'b1;
      en_b_n     <= 1'b1;
      sel_a      <= '0;
      sel_b      <= '0;
      chan       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      dwell_q    <= '0;
      dwell_cnt  <= '0;
      blank_cnt  <= '0;
      mask_q     <= '0;
      cont_q     <= 1'b0;
    end else if (stop) begin
      state      <= IDLE;
      en_a_n     <= 1'b1;
      en_b_n     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else if (hold_act && (state != IDLE)) begin
      // Frozen: every register keeps its value.
      state <= state;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (ch_mask != '0) begin
              mask_q    <= ch_mask;
              cont_q    <= continuous;
              dwell_q   <= (dwell == '0) ? DWELL_W'(1) : dwell;
              chan      <= ch_first;
              if (is_half_b(ch_first)) sel_b <= ch_first[1:0];
              else                     sel_a <= ch_first[1:0];
              blank_cnt <= BLANK_W'(BLANK_CYC);
              busy      <= 1'b1;
              state     <= BLANK;
            end else begin
              frame_done <= 1'b1;
            end
          end
        end

        BLANK: begin
          if (blank_cnt <= BLANK_W'(1)) begin
            dwell_cnt <= dwell_q;
            if (is_half_b(chan)) en_b_n <= 1'b0;
            else                 en_a_n <= 1'b0;
            state <= ACTIVE;
          end else begin
            blank_cnt <= blank_cnt - BLANK_W'(1);
          end
        end

        ACTIVE: begin
          if (dwell_cnt <= DWELL_W'(1)) begin
            en_a_n <= 1'b1;
            en_b_n <= 1'b1;
            if (ch_found) begin
              chan      <= ch_next;
              if (is_half_b(ch_next)) sel_b <= ch_next[1:0];
              else                    sel_a <= ch_next[1:0];
              blank_cnt <= BLANK_W'(BLANK_CYC);
              state     <= BLANK;
            end else begin
              frame_done <= 1'b1;
              if (cont_q) begin
                chan      <= ch_first;
                if (is_half_b(ch_first)) sel_b <= ch_first[1:0];
                else                     sel_a <= ch_first[1:0];
                blank_cnt <= BLANK_W'(BLANK_CYC);
                state     <= BLANK;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end
        end

        default: begin
          en_a_n <= 1'b1;
          en_b_n <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec139_scan_driver.sv
// Self-checking bench: per-cycle expected traces built from the frame timing rules.
module tb_dec139_scan_driver;

  localparam int unsigned DWELL_W   = 8;
  localparam int unsigned BLANK_CYC = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               continuous;
  logic [DWELL_W-1:0] dwell;
  logic [7:0]         ch_mask;
  logic               hold;
  logic [1:0]         sel_a;
  logic               en_a_n;
  logic [1:0]         sel_b;
  logic               en_b_n;
  logic [2:0]         chan;
  logic               busy;
  logic               frame_done;

  always #5 clk = ~clk;

  dec139_scan_driver #(.DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .dwell      (dwell),
    .ch_mask    (ch_mask),
`ifdef DEC139_SCAN_HOLD_EN
    .hold       (hold),
`endif
    .sel_a      (sel_a),
    .en_a_n     (en_a_n),
    .sel_b      (sel_b),
    .en_b_n     (en_b_n),
    .chan       (chan),
    .busy       (busy),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic       en_a_n;
    logic       en_b_n;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [2:0] chan;
    logic       busy;
    logic       frame_done;
  } obs_t;

  typedef struct {
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dw;
    int                 busy_idx;
  } vec_t;

  obs_t       q[$];
  logic [1:0] e_sel_a, e_sel_b;
  logic [2:0] e_chan;
  int         checks = 0;
  int         errors = 0;

  function automatic obs_t mk(input logic ea, input logic eb, input logic bz, input logic fd);
    obs_t o;
    o.en_a_n = ea; o.en_b_n = eb; o.sel_a = e_sel_a; o.sel_b = e_sel_b;
    o.chan = e_chan; o.busy = bz; o.frame_done = fd;
    return o;
  endfunction

  // Expected trace: per enabled channel, BLANK_CYC blank cycles then max(dwell,1) enabled cycles.
  task automatic push_frames(input logic [7:0] mask, input logic [DWELL_W-1:0] dw, input int nframes);
    int d;
    bit first_of_frame;
    d = (dw == 0) ? 1 : int'(dw);
    for (int f = 0; f < nframes; f++) begin
      first_of_frame = 1'b1;
      for (int ch = 0; ch < 8; ch++) begin
        if (mask[ch]) begin
          e_chan = 3'(ch);
          if (ch >= 4) e_sel_b = 2'(ch % 4);
          else         e_sel_a = 2'(ch % 4);
          for (int b = 0; b < int'(BLANK_CYC); b++) begin
            q.push_back(mk(1'b1, 1'b1, 1'b1, (f > 0) && first_of_frame && (b == 0)));
          end
          first_of_frame = 1'b0;
          for (int i = 0; i < d; i++) begin
            q.push_back(mk(ch >= 4, ch < 4, 1'b1, 1'b0));
          end
        end
      end
    end
  endtask

  task automatic push_end(input logic fd);
    q.push_back(mk(1'b1, 1'b1, 1'b0, fd));
    q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic cmp(input string name, input int idx);
    obs_t e, a;
    e = q.pop_front();
    a = '{en_a_n, en_b_n, sel_a, sel_b, chan, busy, frame_done};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d]: got en_a_n=%b en_b_n=%b sel_a=%0d sel_b=%0d chan=%0d busy=%b fd=%b, expected en_a_n=%b en_b_n=%b sel_a=%0d sel_b=%0d chan=%0d busy=%b fd=%b",
               name, idx, a.en_a_n, a.en_b_n, a.sel_a, a.sel_b, a.chan, a.busy, a.frame_done,
               e.en_a_n, e.en_b_n, e.sel_a, e.sel_b, e.chan, e.busy, e.frame_done);
    end
  endtask

  // Called #1 after an edge; compares one queued record per cycle until the queue drains.
  task automatic run_q(input string name, input int hold_idx, input int busy_idx, input int stop_idx);
    int n;
    n = 0;
    while (q.size() > 0) begin
      cmp(name, n);
      start = (n == busy_idx);
      if (n == busy_idx) ch_mask = 8'h01;
      stop = (n == stop_idx);
      if (n == hold_idx) hold = 1'b1;
      if (n == hold_idx + 5) hold = 1'b0;
      n++;
      if (q.size() > 0) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic kick(input logic [7:0] mask, input logic [DWELL_W-1:0] dw, input logic cont);
    ch_mask = mask; dwell = dw; continuous = cont; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic reset_exp();
    e_sel_a = '0; e_sel_b = '0; e_chan = '0;
  endtask

  // Both halves must never be enabled together.
  always @(negedge clk) begin
    checks++;
    if (en_a_n === 1'b0 && en_b_n === 1'b0) begin
      errors++;
      $display("FAIL mutex: en_a_n=%b en_b_n=%b both low", en_a_n, en_b_n);
    end
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hFF, 8'd3, 10};
    vecs[1] = '{8'h92, 8'd2, -1};
    vecs[2] = '{8'h00, 8'd5, -1};
    vecs[3] = '{8'h01, 8'd0, -1};
    vecs[4] = '{8'h80, 8'd1, -1};
    vecs[5] = '{8'h24, 8'd7, 3};
    vecs[6] = '{8'h5A, 8'd1, -1};

    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    dwell = '0; ch_mask = '0; hold = 1'b0;
    reset_exp();
    repeat (2) @(posedge clk);
    #1;
    q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    run_q("reset", -1, -1, -1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].mask != 8'h00) push_frames(vecs[i].mask, vecs[i].dw, 1);
      push_end(1'b1);
      kick(vecs[i].mask, vecs[i].dw, 1'b0);
      run_q($sformatf("vec%0d", i), -1, vecs[i].busy_idx, -1);
    end

    // Continuous 0/7 alternation, then stop on the last enabled cycle of frame 3.
    push_frames(8'h81, 8'd0, 3);
    q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    kick(8'h81, 8'd0, 1'b1);
    run_q("cont_stop", -1, -1, 11);

    // start together with stop in IDLE is ignored.
    q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    ch_mask = 8'hFF; dwell = 8'd2; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    run_q("start_stop", -1, -1, -1);

    // Reset while channel 5 is enabled, then a fresh frame.
    push_frames(8'h20, 8'd4, 1);
    kick(8'h20, 8'd4, 1'b0);
    cmp("rst_mid", 0);
    @(posedge clk); #1;
    cmp("rst_mid", 1);
    @(posedge clk); #1;
    cmp("rst_mid", 2);
    rst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    reset_exp();
    q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
    run_q("rst_mid_after", -1, -1, -1);
    push_frames(8'h92, 8'd2, 1);
    push_end(1'b1);
    kick(8'h92, 8'd2, 1'b0);
    run_q("post_rst", -1, -1, -1);

`ifdef DEC139_SCAN_HOLD_EN
    // Hold for 5 cycles mid-dwell: the enabled record repeats 5 extra times.
    push_frames(8'h0C, 8'd6, 1);
    push_end(1'b1);
    for (int k = 0; k < 5; k++) q.insert(int'(BLANK_CYC) + 2, q[int'(BLANK_CYC) + 2]);
    kick(8'h0C, 8'd6, 1'b0);
    run_q("hold", int'(BLANK_CYC) + 2, -1, -1);
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
